pipe_fifo_vr: RTL and testbench

Synchronous first-word-fall-through FIFO with valid/ready handshakes on both sides. It sits directly downstream of the 8-bit enable-gated pipeline register: that register's `en` pulse becomes `in_valid`, and this block buffers the words until the consumer accepts them. It absorbs consumer stalls of up to DEPTH words and exports occupancy flags for flow control.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_fifo_ptr.sv | 24 ++
 rtl/pipe_fifo_vr.sv | 99 +++++++++
 tb/tb_pipe_fifo_vr.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline FIFO slice: default data width,
// word type and the pointer-width helper (index bits plus one wrap bit).
package pipe_pkg;

  localparam int PIPE_WIDTH = 8;

  typedef logic [PIPE_WIDTH-1:0] pipe_word_t;

  // Pointer carries one extra MSB so full and empty can be told apart.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pipe_fifo_ptr.sv
// FIFO pointer register: advances by one when enabled, wraps naturally
// through its MSB wrap bit, cleared by asynchronous active-low reset.
module pipe_fifo_ptr #(
  parameter int PW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  output logic [PW-1:0] o_ptr
);

  localparam logic [PW-1:0] ONE = 1;

  logic [PW-1:0] r_ptr;

  // Advance on each accepted transfer; modulo wrap gives seamless turnover.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ptr <= '0;
    else if (i_en) r_ptr <= r_ptr + ONE;
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/pipe_fifo_vr.sv
// First-word-fall-through FIFO with valid/ready on both sides.
// Optional high-water mark register and port enabled by PIPE_FIFO_PEAK_EN.
// All status outputs decode from registered pointers only; in_valid and
// out_ready never reach an output combinationally.
module pipe_fifo_vr
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
`ifdef PIPE_FIFO_PEAK_EN
  ,
  output logic [$clog2(DEPTH):0] peak
`endif
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [PW-1:0] w_wr_ptr;
  logic [PW-1:0] w_rd_ptr;
  logic [PW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  assign w_count = w_wr_ptr - w_rd_ptr;
  assign w_empty = (w_wr_ptr == w_rd_ptr);
  assign w_full  = (w_wr_ptr[AW-1:0] == w_rd_ptr[AW-1:0]) &&
                   (w_wr_ptr[AW] != w_rd_ptr[AW]);

  // in_ready is purely !full, so a pop in the same cycle cannot free a slot
  // for the concurrent push; that slot opens on the next cycle.
  assign w_push = in_valid && !w_full;
  assign w_pop  = out_ready && !w_empty;

  pipe_fifo_ptr #(.PW(PW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_push),
    .o_ptr (w_wr_ptr)
  );

  pipe_fifo_ptr #(.PW(PW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_pop),
    .o_ptr (w_rd_ptr)
  );

  // Storage write; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[w_wr_ptr[AW-1:0]] <= in_data;
  end

  assign out_data  = r_mem[w_rd_ptr[AW-1:0]];
  assign out_valid = !w_empty;
  assign in_ready  = !w_full;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = w_count;

`ifdef PIPE_FIFO_PEAK_EN
  localparam logic [PW-1:0] ONE = 1;

  logic [PW-1:0] r_peak;
  logic [PW-1:0] w_count_next;

  // Occupancy after this edge, so peak follows count without lag.
  always_comb begin
    w_count_next = w_count;
    if (w_push && !w_pop)      w_count_next = w_count + ONE;
    else if (w_pop && !w_push) w_count_next = w_count - ONE;
  end

  // High-water mark: monotonic until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_peak <= '0;
    else if (w_count_next > r_peak) r_peak <= w_count_next;
  end

  assign peak = r_peak;
`endif

endmodule

// File: tb/tb_pipe_fifo_vr.sv
// Bench for pipe_fifo_vr: directed scenarios plus random traffic checked
// against a queue-based model of the FIFO.
module tb_pipe_fifo_vr;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [2:0] count;
  logic       full;
  logic       empty;
`ifdef PIPE_FIFO_PEAK_EN
  logic [2:0] peak;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q[$];
  int         m_peak = 0;

  pipe_fifo_vr #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
`ifdef PIPE_FIFO_PEAK_EN
    ,
    .peak      (peak)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // Drive inputs, let one rising edge pass, update the model with the
  // transfers the FIFO rules allow, and return just after the falling edge.
  task automatic step(input logic iv, input logic [7:0] d, input logic ordy);
    bit do_push, do_pop;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    do_push = iv && (q.size() < DEPTH);
    do_pop  = ordy && (q.size() > 0);
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(d);
    if (q.size() > m_peak) m_peak = q.size();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    q.delete();
    m_peak = 0;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count actual=%0d required=0", count); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty actual=%b required=1", empty); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full actual=%b required=0", full); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready actual=%b required=1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid actual=%b required=0", out_valid); end
`ifdef PIPE_FIFO_PEAK_EN
    vectors++; if (peak !== 3'd0) begin miscompares++; $display("FAIL reset_peak actual=%0d required=0", peak); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    logic [7:0] words[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, words[i], 1'b0);
      vectors++; if (count !== 3'(i + 1)) begin miscompares++; $display("FAIL fill_count actual=%0d required=%0d", count, i + 1); end
    end
    vectors++; if (full !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_full actual=%b/%b required=1/0", full, in_ready); end
    step(1'b1, 8'h55, 1'b0);
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL fifth_push_refused actual=%0d required=4", count); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (out_valid !== 1'b1 || out_data !== words[i]) begin miscompares++; $display("FAIL drain_data actual=%b/%h required=1/%h", out_valid, out_data, words[i]); end
      step(1'b0, 8'h00, 1'b1);
    end
    vectors++; if (empty !== 1'b1 || count !== 3'd0) begin miscompares++; $display("FAIL drain_empty actual=%b/%0d required=1/0", empty, count); end
  endtask

  task automatic test_empty_latency();
    in_valid = 1'b1;
    in_data  = 8'hAB;
    out_ready = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL latency_no_forward actual=%b required=0", out_valid); end
    step(1'b1, 8'hAB, 1'b0);
    vectors++; if (out_valid !== 1'b1 || out_data !== 8'hAB) begin miscompares++; $display("FAIL latency_visible actual=%b/%h required=1/ab", out_valid, out_data); end
    step(1'b0, 8'h00, 1'b1);
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL latency_pop_empty actual=%b required=1", empty); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[$];
    logic [7:0] pre0, pre1;
    pre0 = 8'($urandom);
    pre1 = 8'($urandom);
    step(1'b1, pre0, 1'b0);
    step(1'b1, pre1, 1'b0);
    exp = '{pre0, pre1, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    for (int i = 0; i < 8; i++) begin
      vectors++; if (out_data !== exp[i]) begin miscompares++; $display("FAIL b2b_data[%0d] actual=%h required=%h", i, out_data, exp[i]); end
      step(1'b1, 8'(8'hC0 + i), 1'b1);
      vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL b2b_count[%0d] actual=%0d required=2", i, count); end
    end
    for (int i = 0; i < 8 && q.size() > 0; i++) step(1'b0, 8'h00, 1'b1);
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL b2b_drain actual=%b required=1", empty); end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h66;
    out_ready = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL fullpop_in_ready actual=%b required=0", in_ready); end
    vectors++; if (out_data !== q[0]) begin miscompares++; $display("FAIL fullpop_head actual=%h required=%h", out_data, q[0]); end
    step(1'b1, 8'h66, 1'b1);
    vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL fullpop_count actual=%0d required=3", count); end
    step(1'b1, 8'h66, 1'b0);
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL fullpop_accept_next actual=%0d required=4", count); end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    vectors++; if (out_data !== 8'h66 || count !== 3'd1) begin miscompares++; $display("FAIL fullpop_tail actual=%h/%0d required=66/1", out_data, count); end
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0 ? (i % 50 < 25) : 1'b0));
      vectors++; if (count !== 3'(q.size())) begin miscompares++; $display("FAIL rand_count[%0d] actual=%0d required=%0d", i, count, q.size()); end
      vectors++; if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin miscompares++; $display("FAIL rand_flags[%0d] actual=%b/%b required=%b/%b", i, empty, full, q.size() == 0, q.size() == DEPTH); end
      vectors++; if (out_valid !== (q.size() != 0) || in_ready !== (q.size() != DEPTH)) begin miscompares++; $display("FAIL rand_hs[%0d] actual=%b/%b", i, out_valid, in_ready); end
      if (q.size() > 0) begin
        vectors++; if (out_data !== q[0]) begin miscompares++; $display("FAIL rand_data[%0d] actual=%h required=%h", i, out_data, q[0]); end
      end
`ifdef PIPE_FIFO_PEAK_EN
      vectors++; if (peak !== 3'(m_peak)) begin miscompares++; $display("FAIL rand_peak[%0d] actual=%0d required=%0d", i, peak, m_peak); end
`endif
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8 && q.size() > 0; i++) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0);
    vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL mid_setup actual=%0d required=3", count); end
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (empty !== 1'b1 || count !== 3'd0) begin miscompares++; $display("FAIL mid_reset_async actual=%b/%0d required=1/0", empty, count); end
    #1 rst_n = 1'b1;
    q.delete();
    m_peak = 0;
    step(1'b1, 8'h77, 1'b0);
    vectors++; if (out_data !== 8'h77 || count !== 3'd1) begin miscompares++; $display("FAIL mid_after actual=%h/%0d required=77/1", out_data, count); end
`ifdef PIPE_FIFO_PEAK_EN
    vectors++; if (peak !== 3'd1) begin miscompares++; $display("FAIL mid_peak actual=%0d required=1", peak); end
`endif
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    @(negedge clk);
    #1;
    test_fill_drain();
    test_empty_latency();
    test_back_to_back();
    test_full_pop();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
